// File: rtl/matrix_pkg.sv
// Types and constants shared by the matrix operand fetcher and its consumer.
// The enum holds the fetch FSM states. The helper linearises a 2-D index into a row-major offset.
package matrix_pkg;

    localparam int DIM    = 32;
    localparam int ELEM_W = 8;

    typedef logic [DIM-1:0][ELEM_W-1:0] elem_vec_t;
    typedef logic [5:0]                 idx_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } fetch_state_e;

    // Row-major offset of element (major, minor) in a dim x dim matrix.
    function automatic int unsigned lin_index(input int unsigned major,
                                              input int unsigned minor,
                                              input int unsigned dim);
        return major * dim + minor;
    endfunction

endpackage

// File: rtl/read_tag_pipe.sv
// Valid+tag delay line that mirrors the BRAM read latency.
// Each issued read's element index emerges from the line on the cycle its data arrives.
module read_tag_pipe #(
    parameter int DEPTH = 2,
    parameter int TAG_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             empty_next_o
);

    localparam logic [DEPTH-1:0] LAST_BIT = DEPTH'(1) << (DEPTH - 1);

    logic [DEPTH-1:0]            valid_q;
    logic [DEPTH-1:0][TAG_W-1:0] tag_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            tag_q   <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= valid_i;
            tag_q[0]   <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                tag_q[i]   <= tag_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign tag_o   = tag_q[DEPTH-1];

    // After the next edge nothing will be in flight: only the output slot may hold a valid entry now.
    assign empty_next_o = !valid_i && ((valid_q & ~LAST_BIT) == '0);

endmodule

// File: rtl/matrix_fetch.sv
// Fetches row r of A and column c of B from two row-major byte BRAMs.
// Each fetch issues one address pair per cycle and presents both vectors with a one-cycle valid pulse.
module matrix_fetch
    import matrix_pkg::*;
#(
    parameter int DIM          = 32,
    parameter int ADDR_W       = 10,
    parameter int READ_LATENCY = 2
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   new_request,
    input  idx_t                   row_req,
    input  idx_t                   col_req,
    output logic [ADDR_W-1:0]      a_addr,
    input  logic [7:0]             a_data,
    output logic [ADDR_W-1:0]      b_addr,
    input  logic [7:0]             b_data,
    output logic [DIM-1:0][7:0]    matA_row,
    output logic [DIM-1:0][7:0]    matB_col,
    output idx_t                   row_in,
    output idx_t                   col_in,
    output logic                   val_rows,
    output logic                   busy,
    output logic                   req_err
);

    localparam int               TAG_W  = $clog2(DIM);
    localparam logic [TAG_W-1:0] LAST_K = TAG_W'(DIM - 1);

    fetch_state_e       state_q;
    logic [TAG_W-1:0]   k_q;
    idx_t               row_q, col_q;
    logic [ADDR_W-1:0]  a_addr_q, b_addr_q;
    logic               val_q, busy_q, err_q;

    logic [DIM-1:0][7:0] mat_a_q, mat_b_q;
    idx_t                row_in_q, col_in_q;

    logic [TAG_W-1:0]   k_next_d;
    logic [ADDR_W-1:0]  a_addr_d, b_addr_d;
    logic               req_ok_d;

    logic               cap_valid;
    logic [TAG_W-1:0]   cap_tag;
    logic               pipe_empty_next;

    assign req_ok_d = (32'(row_req) < DIM) && (32'(col_req) < DIM);

    // Addresses are registered one step ahead, so the address for k is on the bus while k_q == k.
    always_comb begin
        k_next_d = k_q + 1'b1;
        if (state_q == S_ISSUE) begin
            a_addr_d = ADDR_W'(lin_index(32'(row_q), 32'(k_next_d), DIM));
            b_addr_d = ADDR_W'(lin_index(32'(k_next_d), 32'(col_q), DIM));
        end else begin
            a_addr_d = ADDR_W'(lin_index(32'(row_req), 32'd0, DIM));
            b_addr_d = ADDR_W'(lin_index(32'd0, 32'(col_req), DIM));
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            row_q    <= '0;
            col_q    <= '0;
            a_addr_q <= '0;
            b_addr_q <= '0;
            val_q    <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            val_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    if (new_request) begin
                        if (req_ok_d) begin
                            row_q    <= row_req;
                            col_q    <= col_req;
                            k_q      <= '0;
                            a_addr_q <= a_addr_d;
                            b_addr_q <= b_addr_d;
                            busy_q   <= 1'b1;
                            state_q  <= S_ISSUE;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (k_q == LAST_K) begin
                        state_q <= S_DRAIN;
                    end else begin
                        k_q      <= k_next_d;
                        a_addr_q <= a_addr_d;
                        b_addr_q <= b_addr_d;
                    end
                end
                S_DRAIN: begin
                    if (pipe_empty_next) begin
                        state_q <= S_DONE;
                        val_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    read_tag_pipe #(
        .DEPTH (READ_LATENCY),
        .TAG_W (TAG_W)
    ) u_tag_pipe (
        .clk_i        (clk_in),
        .rst_i        (rst_in),
        .flush_i      (state_q == S_IDLE),
        .valid_i      (state_q == S_ISSUE),
        .tag_i        (k_q),
        .valid_o      (cap_valid),
        .tag_o        (cap_tag),
        .empty_next_o (pipe_empty_next)
    );

    // The echoed indices switch over together with element 0, so old results stay coherent until then.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mat_a_q  <= '0;
            mat_b_q  <= '0;
            row_in_q <= '0;
            col_in_q <= '0;
        end else if (cap_valid) begin
            mat_a_q[cap_tag] <= a_data;
            mat_b_q[cap_tag] <= b_data;
            if (cap_tag == '0) begin
                row_in_q <= row_q;
                col_in_q <= col_q;
            end
        end
    end

    assign a_addr   = a_addr_q;
    assign b_addr   = b_addr_q;
    assign matA_row = mat_a_q;
    assign matB_col = mat_b_q;
    assign row_in   = row_in_q;
    assign col_in   = col_in_q;
    assign val_rows = val_q;
    assign busy     = busy_q;
    assign req_err  = err_q;

endmodule

// File: tb/tb_matrix_fetch.sv
// Bench for matrix_fetch: BRAM models with a fixed read latency and a reference model.
// The model derives expected vectors directly from the matrix contents.
module tb_matrix_fetch;

    localparam int DIM = 32;
    localparam int AW  = 10;
    localparam int RL  = 2;
    localparam int LAT = DIM + RL + 1;

    logic                 clk_in = 1'b0;
    logic                 rst_in;
    logic                 new_request;
    logic [5:0]           row_req, col_req;
    logic [AW-1:0]        a_addr, b_addr;
    logic [7:0]           a_data, b_data;
    logic [DIM-1:0][7:0]  matA_row, matB_col;
    logic [5:0]           row_in, col_in;
    logic                 val_rows, busy, req_err;

    matrix_fetch #(.DIM(DIM), .ADDR_W(AW), .READ_LATENCY(RL)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .new_request (new_request),
        .row_req     (row_req),
        .col_req     (col_req),
        .a_addr      (a_addr),
        .a_data      (a_data),
        .b_addr      (b_addr),
        .b_data      (b_data),
        .matA_row    (matA_row),
        .matB_col    (matB_col),
        .row_in      (row_in),
        .col_in      (col_in),
        .val_rows    (val_rows),
        .busy        (busy),
        .req_err     (req_err)
    );

    always #5 clk_in = ~clk_in;

    logic [7:0] mem_a [DIM*DIM];
    logic [7:0] mem_b [DIM*DIM];
    logic [7:0] a_pipe [RL];
    logic [7:0] b_pipe [RL];

    always @(posedge clk_in) begin
        a_pipe[0] <= mem_a[a_addr];
        b_pipe[0] <= mem_b[b_addr];
        for (int i = 1; i < RL; i++) begin
            a_pipe[i] <= a_pipe[i-1];
            b_pipe[i] <= b_pipe[i-1];
        end
    end
    assign a_data = a_pipe[RL-1];
    assign b_data = b_pipe[RL-1];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int val_pulses = 0;
    int err_pulses = 0;

    always @(negedge clk_in) begin
        if (val_rows) val_pulses++;
        if (req_err)  err_pulses++;
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    function automatic logic [255:0] model_row(input int r);
        logic [255:0] v;
        for (int k = 0; k < DIM; k++) v[k*8 +: 8] = mem_a[r*DIM + k];
        return v;
    endfunction

    function automatic logic [255:0] model_col(input int c);
        logic [255:0] v;
        for (int k = 0; k < DIM; k++) v[k*8 +: 8] = mem_b[k*DIM + c];
        return v;
    endfunction

    task automatic fill_basic();
        for (int r = 0; r < DIM; r++)
            for (int k = 0; k < DIM; k++) begin
                mem_a[r*DIM + k] = 8'(r + k);
                mem_b[k*DIM + r] = 8'(2*k + r);
            end
    endtask

    task automatic fill_identity();
        for (int i = 0; i < DIM*DIM; i++) begin
            mem_a[i] = (i / DIM == i % DIM) ? 8'd1 : 8'd0;
            mem_b[i] = (i / DIM == i % DIM) ? 8'd1 : 8'd0;
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < DIM*DIM; i++) begin
            mem_a[i] = 8'($urandom);
            mem_b[i] = 8'($urandom);
        end
    endtask

    // Drive a request during cycle 0; returns in cycle 1.
    task automatic issue(input int r, input int c);
        row_req     = 6'(r);
        col_req     = 6'(c);
        new_request = 1'b1;
        tick();
        new_request = 1'b0;
        cyc = 1;
    endtask

    task automatic wait_val(output int lat);
        while (!val_rows && cyc < 100) tick();
        lat = cyc;
    endtask

    task automatic check_result(input string name, input int r, input int c);
        check({name, " matA_row"}, 256'(matA_row), model_row(r));
        check({name, " matB_col"}, 256'(matB_col), model_col(c));
        check({name, " row_in"}, 256'(row_in), 256'(r));
        check({name, " col_in"}, 256'(col_in), 256'(c));
    endtask

    task automatic fetch(input string name, input int r, input int c);
        int lat;
        issue(r, c);
        check({name, " busy c1"}, 256'(busy), 256'(1));
        wait_val(lat);
        check({name, " latency"}, 256'(lat), 256'(LAT));
        check_result(name, r, c);
        tick();
        check({name, " val pulse"}, 256'(val_rows), 256'(0));
        check({name, " busy after"}, 256'(busy), 256'(0));
    endtask

    initial begin
        int lat, r, c, vp;
        logic [AW-1:0] a_hold, b_hold;
        logic          busy_seen;
        logic [255:0]  v;

        rst_in = 1'b1; new_request = 1'b0; row_req = '0; col_req = '0;
        fill_basic();
        repeat (3) tick();
        check("rst a_addr", 256'(a_addr), 256'(0));
        check("rst b_addr", 256'(b_addr), 256'(0));
        check("rst matA_row", 256'(matA_row), 256'(0));
        check("rst matB_col", 256'(matB_col), 256'(0));
        check("rst row_in", 256'(row_in), 256'(0));
        check("rst col_in", 256'(col_in), 256'(0));
        check("rst val_rows", 256'(val_rows), 256'(0));
        check("rst busy", 256'(busy), 256'(0));
        check("rst req_err", 256'(req_err), 256'(0));
        rst_in = 1'b0;
        tick();

        // Basic fetch with closed-form expectations.
        fetch("basic", 3, 5);
        for (int k = 0; k < DIM; k++) v[k*8 +: 8] = 8'(2*k + 5);
        check("basic B formula", 256'(matB_col), v);
        $display("basic fetch (3,5) done, latency %0d", LAT);

        fill_identity();
        fetch("identity", 7, 7);
        v = '0; v[7*8 +: 8] = 8'd1;
        check("identity A", 256'(matA_row), v);
        check("identity B", 256'(matB_col), v);
        $display("identity fetch (7,7) done");

        // Busy ignore: second request in cycle 10.
        fill_random();
        val_pulses = 0;
        issue(9, 12);
        while (cyc < 10) tick();
        row_req = 6'd1; col_req = 6'd1; new_request = 1'b1;
        tick();
        new_request = 1'b0;
        wait_val(lat);
        check("ignore latency", 256'(lat), 256'(LAT));
        check_result("ignore", 9, 12);
        repeat (40) tick();
        check("ignore pulses", 256'(val_pulses), 256'(1));
        check("ignore busy", 256'(busy), 256'(0));
        $display("busy-ignore (9,12)+(1,1) done, pulses %0d", val_pulses);

        // Back-to-back: second request raised in the DONE cycle.
        fill_basic();
        issue(0, 0);
        wait_val(lat);
        check("b2b first latency", 256'(lat), 256'(LAT));
        check_result("b2b first", 0, 0);
        row_req = 6'd2; col_req = 6'd4; new_request = 1'b1;
        tick();
        new_request = 1'b0;
        cyc = 1;
        check("b2b busy", 256'(busy), 256'(1));
        wait_val(lat);
        check("b2b gap", 256'(lat), 256'(LAT));
        check_result("b2b second", 2, 4);
        tick();
        $display("back-to-back (0,0)->(2,4) done, gap %0d", lat);

        // Range errors, fixed and random.
        for (int i = 0; i < 3; i++) begin
            r = (i == 0) ? 40 : int'($urandom_range(0, 63));
            c = (i == 0) ? 3  : int'($urandom_range(32, 63));
            a_hold = a_addr; b_hold = b_addr;
            val_pulses = 0; err_pulses = 0; busy_seen = 1'b0;
            issue(r, c);
            check("err pulse c1", 256'(req_err), 256'(1));
            repeat (40) begin
                tick();
                busy_seen |= busy;
            end
            check("err a_addr held", 256'(a_addr), 256'(a_hold));
            check("err b_addr held", 256'(b_addr), 256'(b_hold));
            check("err no val", 256'(val_pulses), 256'(0));
            check("err single pulse", 256'(err_pulses), 256'(1));
            check("err busy", 256'(busy_seen), 256'(0));
            $display("range error request (%0d,%0d) done", r, c);
        end

        // Reset mid-ISSUE, then a clean request.
        fill_basic();
        issue(3, 5);
        while (cyc < 12) tick();
        rst_in = 1'b1;
        #1;
        check("midrst a_addr", 256'(a_addr), 256'(0));
        check("midrst b_addr", 256'(b_addr), 256'(0));
        check("midrst matA_row", 256'(matA_row), 256'(0));
        check("midrst matB_col", 256'(matB_col), 256'(0));
        check("midrst row/col", 256'({row_in, col_in}), 256'(0));
        check("midrst busy", 256'(busy), 256'(0));
        tick();
        rst_in = 1'b0;
        tick();
        fetch("post-reset", 3, 5);
        $display("reset mid-issue then (3,5) done");

        // Randomized fetches against the reference model.
        for (int i = 0; i < 6; i++) begin
            fill_random();
            r = int'($urandom_range(0, DIM-1));
            c = int'($urandom_range(0, DIM-1));
            fetch("random", r, c);
            $display("random fetch %0d (%0d,%0d) done", i, r, c);
        end

        vp = val_pulses;
        repeat (5) tick();
        check("quiet val", 256'(val_pulses), 256'(vp));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
